// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: result broadcasts and ALU issue-queue entries.
package rv32i_types;

    typedef struct packed {
        logic [4:0]  reg_id;
        logic [31:0] data;
    } command_buffer;

    typedef struct packed {
        logic        valid;
        logic [4:0]  dest;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [2:0]  funct3;
        logic        funct7;
        logic        imm;
    } alu_iq_entry_t;

    // A zero tag means the operand already holds its value, so it can never match.
    function automatic logic tag_hit(command_buffer b, logic [4:0] tag);
        return (tag != 5'd0) && (b.reg_id == tag);
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Decode-side enqueue, reservation-station issue and result-broadcast signals of the ALU issue queue.
interface alu_issue_queue_if;
    import rv32i_types::*;

    logic          enq_valid;
    logic          enq_ready;
    logic [4:0]    enq_dest;
    logic [4:0]    enq_r1;
    logic [4:0]    enq_r2;
    logic [31:0]   enq_src1;
    logic [31:0]   enq_src2;
    logic [2:0]    enq_funct3;
    logic          enq_funct7;
    logic          enq_imm;

    logic          rs_free;
    logic          iq_assert;
    logic [4:0]    destination;
    logic [4:0]    r1_o;
    logic [4:0]    r2_o;
    logic [31:0]   src1_o;
    logic [31:0]   src2_o;
    logic [2:0]    funct3;
    logic          funct7;
    logic          imm;

    command_buffer cmd_buf_alu;
    command_buffer cmd_buf_ld_str;
    command_buffer cmd_buf_mul;
    command_buffer cmd_buf_div;

    modport master (
        output enq_valid, enq_dest, enq_r1, enq_r2, enq_src1, enq_src2,
               enq_funct3, enq_funct7, enq_imm, rs_free,
               cmd_buf_alu, cmd_buf_ld_str, cmd_buf_mul, cmd_buf_div,
        input  enq_ready, iq_assert, destination, r1_o, r2_o, src1_o, src2_o,
               funct3, funct7, imm
    );

    modport slave (
        input  enq_valid, enq_dest, enq_r1, enq_r2, enq_src1, enq_src2,
               enq_funct3, enq_funct7, enq_imm, rs_free,
               cmd_buf_alu, cmd_buf_ld_str, cmd_buf_mul, cmd_buf_div,
        output enq_ready, iq_assert, destination, r1_o, r2_o, src1_o, src2_o,
               funct3, funct7, imm
    );

endinterface

// File: rtl/tag_snoop.sv
// Wakes one operand from the four result broadcasts; priority div > mul > ld_str > alu.
module tag_snoop
    import rv32i_types::*;
(
    input  logic [4:0]    tag,
    input  logic [31:0]   value,
    input  command_buffer alu,
    input  command_buffer ld_str,
    input  command_buffer mul,
    input  command_buffer div,
    output logic [4:0]    new_tag,
    output logic [31:0]   new_value
);

    always_comb begin
        new_tag   = tag;
        new_value = value;
        if (tag_hit(div, tag)) begin
            new_tag   = 5'd0;
            new_value = div.data;
        end else if (tag_hit(mul, tag)) begin
            new_tag   = 5'd0;
            new_value = mul.data;
        end else if (tag_hit(ld_str, tag)) begin
            new_tag   = 5'd0;
            new_value = ld_str.data;
        end else if (tag_hit(alu, tag)) begin
            new_tag   = 5'd0;
            new_value = alu.data;
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// In-order circular issue queue of ALU ops with operand wakeup; ALU_IQ_PERF_EN adds
// saturating stall_cnt/full_cnt counters.
module alu_issue_queue
    import rv32i_types::*;
#(
    parameter int unsigned  DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    alu_issue_queue_if.slave bus,
    output logic [PTR_W:0]   count_o
`ifdef ALU_IQ_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      full_cnt
`endif
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    alu_iq_entry_t    q_q [DEPTH];
    alu_iq_entry_t    q_d [DEPTH];
    logic [4:0]       w_r1 [DEPTH];
    logic [4:0]       w_r2 [DEPTH];
    logic [31:0]      w_s1 [DEPTH];
    logic [31:0]      w_s2 [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [4:0]       enq_t1, enq_t2;
    logic [31:0]      enq_v1, enq_v2;
    logic             push, pop;

    // Every stored operand snoops every cycle; the head's result also feeds issue forwarding.
    for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
        tag_snoop u_snoop_1 (
            .tag(q_q[i].r1), .value(q_q[i].src1),
            .alu(bus.cmd_buf_alu), .ld_str(bus.cmd_buf_ld_str),
            .mul(bus.cmd_buf_mul), .div(bus.cmd_buf_div),
            .new_tag(w_r1[i]), .new_value(w_s1[i])
        );
        tag_snoop u_snoop_2 (
            .tag(q_q[i].r2), .value(q_q[i].src2),
            .alu(bus.cmd_buf_alu), .ld_str(bus.cmd_buf_ld_str),
            .mul(bus.cmd_buf_mul), .div(bus.cmd_buf_div),
            .new_tag(w_r2[i]), .new_value(w_s2[i])
        );
    end

    tag_snoop u_enq_snoop_1 (
        .tag(bus.enq_r1), .value(bus.enq_src1),
        .alu(bus.cmd_buf_alu), .ld_str(bus.cmd_buf_ld_str),
        .mul(bus.cmd_buf_mul), .div(bus.cmd_buf_div),
        .new_tag(enq_t1), .new_value(enq_v1)
    );
    tag_snoop u_enq_snoop_2 (
        .tag(bus.enq_r2), .value(bus.enq_src2),
        .alu(bus.cmd_buf_alu), .ld_str(bus.cmd_buf_ld_str),
        .mul(bus.cmd_buf_mul), .div(bus.cmd_buf_div),
        .new_tag(enq_t2), .new_value(enq_v2)
    );

    always_comb begin
        bus.enq_ready   = (count_q != FULL);
        bus.iq_assert   = (count_q != '0) && bus.rs_free && !flush;
        push            = bus.enq_valid && bus.enq_ready;
        pop             = bus.iq_assert;
        count_o         = count_q;
        bus.destination = '0;
        bus.r1_o        = '0;
        bus.r2_o        = '0;
        bus.src1_o      = '0;
        bus.src2_o      = '0;
        bus.funct3      = '0;
        bus.funct7      = 1'b0;
        bus.imm         = 1'b0;
        if (bus.iq_assert) begin
            bus.destination = q_q[head_q].dest;
            bus.r1_o        = w_r1[head_q];
            bus.r2_o        = w_r2[head_q];
            bus.src1_o      = w_s1[head_q];
            bus.src2_o      = w_s2[head_q];
            bus.funct3      = q_q[head_q].funct3;
            bus.funct7      = q_q[head_q].funct7;
            bus.imm         = q_q[head_q].imm;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_d[i] = q_q[i];
            if (q_q[i].valid) begin
                q_d[i].r1   = w_r1[i];
                q_d[i].r2   = w_r2[i];
                q_d[i].src1 = w_s1[i];
                q_d[i].src2 = w_s2[i];
            end
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            q_d[head_q].valid = 1'b0;
            head_d            = head_q + PTR_W'(1);
        end
        if (push) begin
            q_d[tail_q].valid  = 1'b1;
            q_d[tail_q].dest   = bus.enq_dest;
            q_d[tail_q].r1     = enq_t1;
            q_d[tail_q].r2     = enq_t2;
            q_d[tail_q].src1   = enq_v1;
            q_d[tail_q].src2   = enq_v2;
            q_d[tail_q].funct3 = bus.enq_funct3;
            q_d[tail_q].funct7 = bus.enq_funct7;
            q_d[tail_q].imm    = bus.enq_imm;
            tail_d             = tail_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) q_d[i].valid = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef ALU_IQ_PERF_EN
    // Counters survive flush so mispredict-heavy phases stay visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            full_cnt  <= '0;
        end else begin
            if ((count_q != '0) && !bus.rs_free && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (bus.enq_valid && !bus.enq_ready && (full_cnt != '1)) begin
                full_cnt <= full_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios then random traffic vs a queue model.
module tb_alu_issue_queue;
    import rv32i_types::*;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [4:0]  dest;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [2:0]  f3;
        logic        f7;
        logic        im;
    } op_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [3:0] count_o;
`ifdef ALU_IQ_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] full_cnt;
`endif

    alu_issue_queue_if bus ();

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .bus(bus),
        .count_o(count_o)
`ifdef ALU_IQ_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .full_cnt(full_cnt)
`endif
    );

    always #5 clk = ~clk;

    op_t model[$];
    int  total  = 0;
    int  passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Highest-priority broadcast first; the first matching one supplies the value.
    function automatic void snoop(inout logic [4:0] t, inout logic [31:0] v);
        command_buffer b[4];
        b[0] = bus.cmd_buf_div;
        b[1] = bus.cmd_buf_mul;
        b[2] = bus.cmd_buf_ld_str;
        b[3] = bus.cmd_buf_alu;
        if (t == 5'd0) return;
        for (int k = 0; k < 4; k++) begin
            if (b[k].reg_id == t) begin
                t = 5'd0;
                v = b[k].data;
                return;
            end
        end
    endfunction

    task automatic idle();
        bus.enq_valid      = 1'b0;
        bus.enq_dest       = '0;
        bus.enq_r1         = '0;
        bus.enq_r2         = '0;
        bus.enq_src1       = '0;
        bus.enq_src2       = '0;
        bus.enq_funct3     = '0;
        bus.enq_funct7     = 1'b0;
        bus.enq_imm        = 1'b0;
        bus.rs_free        = 1'b0;
        bus.cmd_buf_alu    = '0;
        bus.cmd_buf_ld_str = '0;
        bus.cmd_buf_mul    = '0;
        bus.cmd_buf_div    = '0;
        flush              = 1'b0;
    endtask

    task automatic set_op(input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2);
        bus.enq_dest   = d;
        bus.enq_r1     = r1;
        bus.enq_r2     = r2;
        bus.enq_src1   = $urandom;
        bus.enq_src2   = $urandom;
        bus.enq_funct3 = 3'($urandom);
        bus.enq_funct7 = 1'($urandom);
        bus.enq_imm    = 1'($urandom);
    endtask

    // Mid-cycle comparison of all outputs against the model.
    task automatic eval();
        op_t  h;
        logic exp_iq;
        #3;
        exp_iq = (model.size() != 0) && bus.rs_free && !flush;
        chk("count", 64'(count_o), 64'(model.size()));
        chk("enq_ready", 64'(bus.enq_ready), 64'(model.size() != DEPTH));
        chk("iq_assert", 64'(bus.iq_assert), 64'(exp_iq));
        if (exp_iq) begin
            h = model[0];
            snoop(h.r1, h.s1);
            snoop(h.r2, h.s2);
            chk("head_fields", 64'({bus.destination, bus.r1_o, bus.r2_o, bus.funct3, bus.funct7,
                bus.imm}), 64'({h.dest, h.r1, h.r2, h.f3, h.f7, h.im}));
            chk("head_src1", 64'(bus.src1_o), 64'(h.s1));
            chk("head_src2", 64'(bus.src2_o), 64'(h.s2));
        end else begin
            chk("idle_zero", 64'({bus.destination, bus.r1_o, bus.r2_o, bus.funct3, bus.funct7,
                bus.imm, bus.src1_o | bus.src2_o}), 64'd0);
        end
    endtask

    // Apply this cycle's effects to the model, then move to just after the next edge.
    task automatic advance();
        op_t e;
        bit  rdy;
        rdy = (model.size() != DEPTH);
        if (flush) begin
            model.delete();
        end else begin
            if (model.size() != 0 && bus.rs_free) void'(model.pop_front());
            for (int k = 0; k < model.size(); k++) begin
                e = model[k];
                snoop(e.r1, e.s1);
                snoop(e.r2, e.s2);
                model[k] = e;
            end
            if (bus.enq_valid && rdy) begin
                e.dest = bus.enq_dest;
                e.r1   = bus.enq_r1;
                e.r2   = bus.enq_r2;
                e.s1   = bus.enq_src1;
                e.s2   = bus.enq_src2;
                e.f3   = bus.enq_funct3;
                e.f7   = bus.enq_funct7;
                e.im   = bus.enq_imm;
                snoop(e.r1, e.s1);
                snoop(e.r2, e.s2);
                model.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        bus.rs_free = 1'b1;
        chk("reset_count", 64'(count_o), 64'd0);
        chk("reset_ready", 64'(bus.enq_ready), 64'd1);
        chk("reset_iq", 64'(bus.iq_assert), 64'd0);
        reset = 1'b0;

        // Three ready ops issue back to back, one cycle after the first push.
        for (int i = 0; i < 4; i++) begin
            bus.enq_valid = (i < 3);
            set_op(5'(i + 1), 5'd0, 5'd0);
            eval();
            if (i > 0) chk("in_order_dest", 64'({bus.iq_assert, bus.destination}),
                64'({1'b1, 5'(i)}));
            advance();
        end
        idle();

        // Queued wakeup from the mul broadcast.
        set_op(5'd10, 5'd7, 5'd0);
        bus.enq_valid = 1'b1;
        eval();
        advance();
        bus.enq_valid   = 1'b0;
        bus.cmd_buf_mul = {5'd7, 32'hDEADBEEF};
        eval();
        advance();
        bus.cmd_buf_mul = '0;
        bus.rs_free     = 1'b1;
        eval();
        chk("wake_r1", 64'(bus.r1_o), 64'd0);
        chk("wake_src1", 64'(bus.src1_o), 64'hDEADBEEF);
        advance();
        idle();

        // Broadcast landing on the issue cycle is forwarded.
        set_op(5'd11, 5'd0, 5'd4);
        bus.enq_valid = 1'b1;
        eval();
        advance();
        bus.enq_valid   = 1'b0;
        bus.rs_free     = 1'b1;
        bus.cmd_buf_alu = {5'd4, 32'h12};
        eval();
        chk("fwd_iq", 64'(bus.iq_assert), 64'd1);
        chk("fwd_r2", 64'(bus.r2_o), 64'd0);
        chk("fwd_src2", 64'(bus.src2_o), 64'h12);
        advance();
        idle();

        // Fill, drop the ninth push, then push+pop while full only pops.
        for (int i = 0; i < 9; i++) begin
            bus.enq_valid = 1'b1;
            set_op(5'(i + 1), 5'd0, 5'd0);
            eval();
            if (i == 8) chk("full_ready", 64'(bus.enq_ready), 64'd0);
            advance();
        end
        bus.rs_free = 1'b1;
        set_op(5'd20, 5'd0, 5'd0);
        eval();
        chk("full_pop_iq", 64'(bus.iq_assert), 64'd1);
        advance();
        eval();
        chk("full_pop_count", 64'(count_o), 64'd7);
        advance();
        for (int i = 0; i < 20; i++) begin
            set_op(5'($urandom_range(1, 31)), 5'd0, 5'd0);
            eval();
            advance();
        end
        bus.enq_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            eval();
            advance();
        end
        idle();

        // div beats ld_str on the same tag.
        set_op(5'd12, 5'd9, 5'd0);
        bus.enq_valid = 1'b1;
        eval();
        advance();
        bus.enq_valid      = 1'b0;
        bus.cmd_buf_div    = {5'd9, 32'hA};
        bus.cmd_buf_ld_str = {5'd9, 32'hB};
        eval();
        advance();
        idle();
        bus.rs_free = 1'b1;
        eval();
        chk("prio_src1", 64'(bus.src1_o), 64'hA);
        advance();
        idle();

        // Flush beats a same-cycle push.
        for (int i = 0; i < 5; i++) begin
            bus.enq_valid = 1'b1;
            set_op(5'(i + 1), 5'd3, 5'd0);
            eval();
            advance();
        end
        flush       = 1'b1;
        bus.rs_free = 1'b1;
        set_op(5'd30, 5'd0, 5'd0);
        eval();
        chk("flush_iq", 64'(bus.iq_assert), 64'd0);
        advance();
        flush         = 1'b0;
        bus.enq_valid = 1'b0;
        eval();
        chk("flush_count", 64'(count_o), 64'd0);
        advance();
        idle();

        // Asynchronous reset empties the queue without a clock edge.
        for (int i = 0; i < 3; i++) begin
            bus.enq_valid = 1'b1;
            set_op(5'(i + 1), 5'd0, 5'd0);
            eval();
            advance();
        end
        bus.enq_valid = 1'b0;
        bus.rs_free   = 1'b1;
        reset         = 1'b1;
        #1;
        chk("async_reset_count", 64'(count_o), 64'd0);
        chk("async_reset_ready", 64'(bus.enq_ready), 64'd1);
        chk("async_reset_iq", 64'(bus.iq_assert), 64'd0);
        model.delete();
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle();

        // Random traffic with frequent tag collisions on the broadcasts.
        for (int n = 0; n < 600; n++) begin
            bus.enq_valid = ($urandom_range(0, 3) != 0);
            set_op(5'($urandom_range(1, 31)),
                   ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7)),
                   ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7)));
            bus.rs_free        = ($urandom_range(0, 1) == 0);
            flush              = ($urandom_range(0, 49) == 0);
            bus.cmd_buf_alu    = {5'($urandom_range(0, 7)), 32'($urandom)};
            bus.cmd_buf_ld_str = {5'($urandom_range(0, 7)), 32'($urandom)};
            bus.cmd_buf_mul    = {5'($urandom_range(0, 7)), 32'($urandom)};
            bus.cmd_buf_div    = {5'($urandom_range(0, 7)), 32'($urandom)};
            eval();
            advance();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Circular FIFO of decoded ALU ops, sitting between decode/rename and the ALU reservation station.
- Accepts one op per cycle from decode and holds operand tags and values.
- Snoops the four command-buffer broadcasts so queued operands wake up while they wait.
- Issues the head op to the reservation station through the iq_assert/free_o handshake.

Parameters:
DEPTH, 8, number of entries; power of 2, at least 2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
flush  in  1  synchronous clear of all entries (branch mispredict)
enq_valid  in  1  decode presents an ALU op
enq_ready  out  1  queue not full
enq_dest  in  5  destination tag
enq_r1, enq_r2  in  5 each  source tags; 0 = value ready
enq_src1, enq_src2  in  32 each  source values, valid when tag is 0
enq_funct3  in  3  funct3
enq_funct7  in  1  funct7 bit 5
enq_imm  in  1  op is immediate form
rs_free  in  1  reservation station free_o
iq_assert  out  1  head op issued this cycle
destination, r1_o, r2_o, src1_o, src2_o, funct3, funct7, imm  out  5/5/5/32/32/3/1/1  head op fields, forwarded
cmd_buf_alu, cmd_buf_ld_str, cmd_buf_mul, cmd_buf_div  in  command_buffer  result broadcasts (reg_id, data)
count_o  out  PTR_W+1  occupancy

Behaviour:
- Reset: all entry valid bits 0; head = tail = 0; count_o = 0; enq_ready = 1; iq_assert = 0.
- Output fields are don't-care while iq_assert = 0 and are driven to 0 in that case.
- Enqueue:
  - enq_ready = (count_o != DEPTH), registered state only.
  - A push happens when enq_valid && enq_ready; the entry is written at tail and tail increments modulo DEPTH.
- Issue:
  - iq_assert = (count_o != 0) && rs_free, combinational.
  - When iq_assert = 1, the head pops at the edge and head increments modulo DEPTH.
  - Ops issue strictly in order; there is no skipping.
- Wakeup:
  - Every cycle, each valid entry compares each nonzero tag against every broadcast reg_id.
  - A broadcast with reg_id = 0 never matches.
  - On a match the tag becomes 0 and the value becomes the broadcast data.
  - Priority when several broadcasts match: div > mul > ld_str > alu.
- Enqueue-time snoop: enq_r1/enq_r2 are matched against the same-cycle broadcasts before the write, so no wakeup is lost.
- Issue-time forwarding: r1_o/src1_o and r2_o/src2_o reflect a same-cycle broadcast match on the head entry (tag 0, broadcast data). The reservation station therefore never misses a broadcast that lands on the issue cycle.
- Pointers wrap from DEPTH-1 to 0. Full vs empty is decided by count_o, not by pointer equality alone.
- Simultaneous push and pop:
  - Allowed when not full; count_o is unchanged.
  - When full, the push is refused (enq_ready = 0) even if a pop occurs that cycle.
- Push into an empty queue: the op becomes visible at the head the next cycle, giving a minimum latency of 1 cycle from enqueue to iq_assert.
- flush:
  - Clears valid bits, pointers and count next edge.
  - Takes priority over a same-cycle push, pop or wakeup.
  - iq_assert is forced to 0 in the flush cycle.
- Reset asserted mid-operation: the queue empties immediately regardless of the clock.

Optional Feature:
- Macro ALU_IQ_PERF_EN.
- When defined:
  - Adds output stall_cnt (32 bits), counting cycles with count_o != 0 && !rs_free.
  - Adds output full_cnt (32 bits), counting cycles with enq_valid && !enq_ready.
  - Both counters saturate at all-ones, clear on reset, and do not clear on flush.
- When undefined: no counters and no extra ports.

Decomposition:
- The alu_iq_entry_t struct (valid, dest, r1, r2, src1, src2, funct3, funct7, imm) goes in rv32i_types beside command_buffer.
- Sub-module tag_snoop: combinational; takes a tag, a value and the four broadcasts, and returns the updated tag and value with the fixed priority.
  - Instanced per entry operand, for enqueue and for head forwarding.

Test Plan:
- Push 3 ready ops (r1 = r2 = 0) with rs_free = 1 -> iq_assert on 3 consecutive cycles starting 1 cycle after the first push, in order, with the correct destinations.
- Push an op with r1 = 7, hold rs_free = 0, broadcast cmd_buf_mul reg_id = 7, data = 0xDEADBEEF -> when later issued, r1_o = 0 and src1_o = 0xDEADBEEF.
- Head op with r2 = 4 and rs_free = 1; in the same cycle cmd_buf_alu reg_id = 4, data = 0x12 -> iq_assert = 1, r2_o = 0, src2_o = 0x12.
- Fill to DEPTH = 8 with rs_free = 0 -> enq_ready = 0 and a 9th push is dropped.
  - Then rs_free = 1 with a simultaneous push: the first cycle pops only.
  - Pointers wrap correctly over 20 further ops.
- Both cmd_buf_div and cmd_buf_ld_str broadcast reg_id = 9 (data 0xA and 0xB) for an entry with r1 = 9 -> src1 = 0xA.
- 5 entries queued, then flush with enq_valid = 1 -> next cycle count_o = 0, iq_assert = 0, and the pushed op is discarded.
  - Separately, reset pulsed mid-stream -> immediate empty state.
